// File: rtl/sine_lut_arbiter.sv
// Round-robin arbiter that shares one combinational sine LUT among NUM_REQ
// requesters. One lookup is in flight at a time: IDLE grants and registers the
// clamped LUT address, LOOKUP captures the LUT output, RESP presents the result
// until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. Requesters hold req_valid/req_addr until they see their
// req_ready bit (dropping earlier simply means no grant). req_ready is
// combinational and at most one-hot, and only in IDLE. resp_valid stays high
// with stable resp_data/resp_id/resp_clamped until resp_ready is seen at an edge.
module sine_lut_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_MIN = -1500,
   parameter int ADDR_MAX = 1500,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]         lut_address,
   input  logic [DATA_W-1:0]         lut_data,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_clamped,
   output logic                      busy,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic signed [ADDR_W-1:0] MIN_A = ADDR_W'(ADDR_MIN);
   localparam logic signed [ADDR_W-1:0] MAX_A = ADDR_W'(ADDR_MAX);
   localparam logic [ID_W-1:0]          LAST_ID = ID_W'(NUM_REQ - 1);

   state_t                     state_q, state_d;
   logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]          lut_address_q, lut_address_d;
   logic [DATA_W-1:0]          resp_data_q, resp_data_d;
   logic [ID_W-1:0]            resp_id_q, resp_id_d;
   logic                       resp_clamped_q, resp_clamped_d;

   logic                       grant_found;
   logic [ID_W-1:0]            grant_idx;
   logic signed [ADDR_W-1:0]   sel_addr;
   logic signed [ADDR_W-1:0]   clamp_addr;
   logic                       out_of_range;

   // Index of the requester 'off' positions after 'base', wrapping at NUM_REQ.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return ID_W'(s);
   endfunction

   // Round-robin search: first valid requester starting at rr_ptr.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
            grant_found = 1'b1;
            grant_idx   = wrap_add(rr_ptr_q, k);
         end
      end
   end

   // Select the granted address and clamp it (signed) into the legal LUT range.
   always_comb begin
      sel_addr     = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
      clamp_addr   = sel_addr;
      out_of_range = 1'b0;
      if (sel_addr < MIN_A) begin
         clamp_addr   = MIN_A;
         out_of_range = 1'b1;
      end else if (sel_addr > MAX_A) begin
         clamp_addr   = MAX_A;
         out_of_range = 1'b1;
      end
   end

   // Next-state, register updates and the grant strobe.
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      lut_address_d  = lut_address_q;
      resp_data_d    = resp_data_q;
      resp_id_d      = resp_id_q;
      resp_clamped_d = resp_clamped_q;
      req_ready      = '0;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               req_ready      = NUM_REQ'(1) << grant_idx;
               lut_address_d  = clamp_addr;
               resp_id_d      = grant_idx;
               resp_clamped_d = out_of_range;
               rr_ptr_d       = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
               state_d        = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            resp_data_d = lut_data;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // A grant shown during reset would never be taken, so hide it.
      if (rst) begin
         req_ready = '0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         rr_ptr_q       <= '0;
         lut_address_q  <= '0;
         resp_data_q    <= '0;
         resp_id_q      <= '0;
         resp_clamped_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         lut_address_q  <= lut_address_d;
         resp_data_q    <= resp_data_d;
         resp_id_q      <= resp_id_d;
         resp_clamped_q <= resp_clamped_d;
      end
   end

   assign lut_address  = lut_address_q;
   assign resp_valid   = (state_q == S_RESP);
   assign resp_id      = resp_id_q;
   assign resp_data    = resp_data_q;
   assign resp_clamped = resp_clamped_q;
   assign busy         = (state_q != S_IDLE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Testbench for sine_lut_arbiter: a vector table of single lookups (clamp
// boundaries, known sine values), hand-written sequences for round-robin order,
// backpressure and mid-flight reset, then randomized traffic against a
// transaction-level model with an expected-response queue.
module tb_sine_lut_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int ID_W    = 2;
   localparam int A_MIN   = -1500;
   localparam int A_MAX   = 1500;
   localparam int EXP_W   = ID_W + 1 + DATA_W;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic [ADDR_W-1:0]         lut_address;
   logic [DATA_W-1:0]         lut_data;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [ID_W-1:0]           resp_id;
   logic [DATA_W-1:0]         resp_data;
   logic                      resp_clamped;
   logic                      busy;
   logic [1:0]                dbg_state;

   int n_vec = 0;
   int n_bad = 0;

   logic [EXP_W-1:0] exp_q[$];
   int m_ptr;
   bit m_busy;
   int m_ready_at;
   int cyc;

   typedef struct {
      int                 id;
      logic signed [31:0] addr;
      logic signed [31:0] exp_addr;
      logic               exp_clamp;
      logic               has_data;
      int                 exp_data;
   } vec_t;

   vec_t vecs[11];

   sine_lut_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .ADDR_MIN(A_MIN), .ADDR_MAX(A_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .lut_address(lut_address), .lut_data(lut_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .resp_clamped(resp_clamped),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Behavioural sine LUT: round(sin(addr/300) * 65536).
   function automatic logic [DATA_W-1:0] lut_fn(input logic signed [ADDR_W-1:0] a);
      real r;
      r = $sin(real'(a) / 300.0) * 65536.0;
      return DATA_W'(int'(r));
   endfunction

   always_comb lut_data = lut_fn(lut_address);

   function automatic int clamp_m(input int a);
      if (a < A_MIN) return A_MIN;
      if (a > A_MAX) return A_MAX;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_near(input string name, input logic [DATA_W-1:0] act, input int exp);
      int d;
      n_vec++;
      d = int'($signed(act)) - exp;
      if ($isunknown(act) || d > 1 || d < -1) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (+-1)", name, $signed(act), exp);
      end
   endtask

   task automatic set_addr(input int i, input int a);
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endtask

   function automatic int rand_addr();
      int edges[6];
      edges = '{-1501, -1500, 1500, 1501, -2000, 3000};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return int'($urandom_range(0, 5000)) - 2500;
   endfunction

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One isolated lookup: grant, registered address, response two cycles later.
   task automatic single_txn(input vec_t v);
      int exp_d;
      exp_d = v.has_data ? v.exp_data : int'($signed(lut_fn(v.exp_addr)));
      set_addr(v.id, v.addr);
      req_valid = NUM_REQ'(1) << v.id;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("vec_req_ready", 32'(req_ready), 32'(NUM_REQ'(1) << v.id));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("vec_lut_address", lut_address, v.exp_addr);
      chk("vec_lookup_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("vec_resp_valid", 32'(resp_valid), 32'd1);
      chk("vec_resp_id", 32'(resp_id), 32'(v.id));
      chk("vec_resp_clamped", 32'(resp_clamped), 32'(v.exp_clamp));
      chk_near("vec_resp_data", resp_data, exp_d);
      @(posedge clk); #1;
      @(negedge clk);
      chk("vec_after_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   // One cycle of random traffic checked against the transaction-level model.
   task automatic rnd_cycle(input bit allow_new);
      logic [NUM_REQ-1:0] exp_rdy;
      logic [EXP_W-1:0]   e;
      int g, idx, a, ca;
      @(negedge clk);
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_resp_valid", 32'(resp_valid), 32'(m_busy && cyc >= m_ready_at));
      if (m_busy && cyc >= m_ready_at && resp_ready) begin
         e = exp_q.pop_front();
         chk("rnd_resp_id", 32'(resp_id), 32'(e[EXP_W-1 -: ID_W]));
         chk("rnd_resp_clamped", 32'(resp_clamped), 32'(e[DATA_W]));
         chk_near("rnd_resp_data", resp_data, int'($signed(e[DATA_W-1:0])));
         m_busy = 1'b0;
      end
      if (g >= 0) begin
         a = int'($signed(req_addr[g*ADDR_W +: ADDR_W]));
         ca = clamp_m(a);
         exp_q.push_back({ID_W'(g), (ca != a), lut_fn(ca)});
         m_busy = 1'b1;
         m_ready_at = cyc + 2;
         m_ptr = (g + 1) % NUM_REQ;
      end
      @(posedge clk); #1;
      cyc++;
      resp_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (exp_rdy[i]) begin
            req_valid[i] = 1'b0;
         end else if (req_valid[i]) begin
            if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
         end else if (allow_new && $urandom_range(0, 3) == 0) begin
            set_addr(i, rand_addr());
            req_valid[i] = 1'b1;
         end
      end
   endtask

   int g_id[8];
   int g_cyc[8];
   int n_g;
   int stale;
   int bp_exp;

   initial begin
      vecs[0]  = '{2, 300, 300, 1'b0, 1'b1, 55147};
      vecs[1]  = '{0, -2000, -1500, 1'b1, 1'b1, 62844};
      vecs[2]  = '{1, 1500, 1500, 1'b0, 1'b1, -62844};
      vecs[3]  = '{3, -1500, -1500, 1'b0, 1'b1, 62844};
      vecs[4]  = '{0, 2000, 1500, 1'b1, 1'b1, -62844};
      vecs[5]  = '{1, 0, 0, 1'b0, 1'b1, 0};
      vecs[6]  = '{2, 1501, 1500, 1'b1, 1'b1, -62844};
      vecs[7]  = '{3, -1501, -1500, 1'b1, 1'b1, 62844};
      vecs[8]  = '{0, 32'sh80000000, -1500, 1'b1, 1'b1, 62844};
      vecs[9]  = '{1, 32'sh7fffffff, 1500, 1'b1, 1'b1, -62844};
      vecs[10] = '{2, 1499, 1499, 1'b0, 1'b0, 0};

      // Reset state, with every requester asking during reset.
      rst = 1'b1;
      req_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) set_addr(i, 300);
      req_valid = '1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_lut_address", lut_address, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_resp_clamped", 32'(resp_clamped), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;

      // Table of single lookups.
      for (int v = 0; v < 11; v++) single_txn(vecs[v]);

      // All requesters continuously: order 0,1,2,3,0,... one grant per 3 cycles.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_addr(i, i * 100 - 150);
      req_valid = '1;
      resp_ready = 1'b1;
      n_g = 0;
      for (int c = 0; c < 40 && n_g < 8; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            chk("rr_onehot", 32'($countones(req_ready)), 32'd1);
            g_id[n_g] = onehot_idx(req_ready);
            g_cyc[n_g] = c;
            n_g++;
         end
         @(posedge clk); #1;
      end
      chk("rr_grant_count", 32'(n_g), 32'd8);
      for (int k = 0; k < n_g; k++) begin
         chk("rr_order", 32'(g_id[k]), 32'(k % NUM_REQ));
         if (k > 0) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
      end
      req_valid = '0;

      // Backpressure: response held 10 cycles, then next grant follows rr_ptr.
      do_reset();
      set_addr(1, 450);
      set_addr(2, -900);
      bp_exp = int'($signed(lut_fn(450)));
      req_valid = 4'b0110;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("bp_grant", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("bp_lookup_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_id", 32'(resp_id), 32'd1);
         chk_near("bp_data", resp_data, bp_exp);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_handshake_valid", 32'(resp_valid), 32'd1);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle", 32'(busy), 32'd0);
      chk("bp_valid_drop", 32'(resp_valid), 32'd0);
      chk("bp_next_grant", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      req_valid = '0;

      // Reset while in LOOKUP: response discarded, rr_ptr back to 0.
      do_reset();
      set_addr(1, 600);
      req_valid = 4'b0010;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("rmid_grant", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("rmid_in_lookup", 32'(busy), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_resp_valid", 32'(resp_valid), 32'd0);
      chk("rmid_resp_data", resp_data, 32'd0);
      chk("rmid_resp_id", 32'(resp_id), 32'd0);
      chk("rmid_lut_address", lut_address, 32'd0);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (resp_valid) stale++;
      end
      chk("rmid_no_stale", 32'(stale), 32'd0);
      @(posedge clk); #1;
      req_valid = '1;
      @(negedge clk);
      chk("rmid_rr_ptr", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;

      // Random traffic against the model.
      do_reset();
      m_ptr = 0;
      m_busy = 1'b0;
      m_ready_at = 0;
      cyc = 0;
      exp_q.delete();
      for (int c = 0; c < 10000; c++) rnd_cycle(1'b1);
      for (int c = 0; c < 12; c++) rnd_cycle(1'b0);
      chk("rnd_all_answered", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
